// File: rtl/lif_scheduler.sv
// Time-multiplexed leaky integrate-and-fire scheduler: events accumulate while idle, a tick sweeps
// every neuron once. Optional build macro LIF_SCHED_REFRACTORY_EN adds a one-sweep refractory period.
module lif_scheduler #(
  parameter int unsigned V_SIZE    = 4,
  parameter int unsigned N_NEURONS = 4,
  parameter int unsigned THRESHOLD = 8,
  parameter int unsigned LEAK      = 1,
  localparam int unsigned AW       = $clog2(N_NEURONS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          tick,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [AW-1:0] in_addr,
  input  logic [V_SIZE:0] in_weight,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [AW-1:0] out_addr,
  output logic          sweep_done,
  output logic          tick_overrun
);

  localparam int unsigned VW = V_SIZE + 1;
  localparam logic [V_SIZE:0] LeakW   = VW'(LEAK);
  localparam logic [V_SIZE:0] ThreshW = VW'(THRESHOLD);
  localparam logic [AW-1:0]   LastIdx = AW'(N_NEURONS - 1);

  typedef enum logic [1:0] {StIdle, StSweep, StHold} state_e;

  state_e            state_q;
  logic [AW-1:0]     idx_q;
  logic [V_SIZE-1:0] v_q   [N_NEURONS];
  logic [V_SIZE:0]   acc_q [N_NEURONS];
  logic              sweep_done_q;
  logic              tick_overrun_q;
`ifdef LIF_SCHED_REFRACTORY_EN
  logic [N_NEURONS-1:0] fired_q;
`endif

  logic            addr_ok;
  logic [V_SIZE:0] ev_sum, ev_clip;
  logic [V_SIZE:0] cur_acc, s, d, r;
  logic            fire, commit;

  // Event accumulation: clip to all-ones on any overflow indication.
  always_comb begin
    addr_ok = (32'(in_addr) < N_NEURONS);
    ev_sum  = acc_q[in_addr] + in_weight;
    ev_clip = (acc_q[in_addr][V_SIZE] || in_weight[V_SIZE] || ev_sum[V_SIZE]) ? '1 : ev_sum;
  end

  // Neuron update for the current sweep index; stable through HOLD since nothing changes there.
  always_comb begin
    cur_acc = acc_q[idx_q];
`ifdef LIF_SCHED_REFRACTORY_EN
    if (fired_q[idx_q]) cur_acc = '0;
`endif
    s = {1'b0, v_q[idx_q]} + cur_acc;
    d = s - LeakW;
    if (cur_acc[V_SIZE])  r = '1;
    else if (s > LeakW)   r = d[V_SIZE] ? '1 : d;
    else                  r = '0;
    fire   = (r >= ThreshW);
    commit = ((state_q == StSweep) && (!fire || out_ready)) ||
             ((state_q == StHold) && out_ready);
  end

  assign in_ready     = (state_q == StIdle);
  assign out_valid    = (state_q != StIdle) && fire;
  assign out_addr     = out_valid ? idx_q : '0;
  assign sweep_done   = sweep_done_q;
  assign tick_overrun = tick_overrun_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= StIdle;
      idx_q          <= '0;
      sweep_done_q   <= 1'b0;
      tick_overrun_q <= 1'b0;
      for (int i = 0; i < int'(N_NEURONS); i++) begin
        v_q[i]   <= '0;
        acc_q[i] <= '0;
      end
`ifdef LIF_SCHED_REFRACTORY_EN
      fired_q <= '0;
`endif
    end else begin
      sweep_done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (in_valid && addr_ok) acc_q[in_addr] <= ev_clip;
          if (tick) begin
            state_q <= StSweep;
            idx_q   <= '0;
          end
        end
        StSweep, StHold: begin
          if (tick) tick_overrun_q <= 1'b1;
          if (commit) begin
            v_q[idx_q]   <= fire ? '0 : r[V_SIZE-1:0];
            acc_q[idx_q] <= '0;
`ifdef LIF_SCHED_REFRACTORY_EN
            fired_q[idx_q] <= fire;
`endif
            if (idx_q == LastIdx) begin
              state_q      <= StIdle;
              sweep_done_q <= 1'b1;
            end else begin
              state_q <= StSweep;
              idx_q   <= idx_q + AW'(1);
            end
          end else begin
            state_q <= StHold;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_lif_scheduler.sv
// Randomized self-checking bench for lif_scheduler against a per-sweep behavioural model.
// Expectations follow LIF_SCHED_REFRACTORY_EN when it is defined for the build.
module tb_lif_scheduler;

  localparam int N = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tick = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [1:0] in_addr = '0;
  logic [4:0] in_weight = '0;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic [1:0] out_addr;
  logic       sweep_done;
  logic       tick_overrun;

  lif_scheduler dut (
    .clk          (clk),
    .rst          (rst),
    .tick         (tick),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_addr      (in_addr),
    .in_weight    (in_weight),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_addr     (out_addr),
    .sweep_done   (sweep_done),
    .tick_overrun (tick_overrun)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  int m_v     [N];
  int m_acc   [N];
  bit m_fired [N];
  bit m_overrun;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_v[i] = 0; m_acc[i] = 0; m_fired[i] = 0;
    end
    m_overrun = 0;
  endtask

  function automatic void model_event(input int addr, input int w);
    int sum;
    if (addr >= N) return;
    sum = m_acc[addr] + w;
    m_acc[addr] = (m_acc[addr] >= 16 || w >= 16 || sum >= 16) ? 31 : sum;
  endfunction

  // One whole timestep: returns the ordered list of neurons expected to fire.
  task automatic model_sweep(output int fires[$]);
    int a, s, r;
    bit f;
    fires = {};
    for (int i = 0; i < N; i++) begin
      a = m_acc[i];
`ifdef LIF_SCHED_REFRACTORY_EN
      if (m_fired[i]) a = 0;
`endif
      s = m_v[i] + a;
      if (a >= 16)   r = 31;
      else if (s > 1) r = (s - 1 >= 16) ? 31 : s - 1;
      else           r = 0;
      f = (r >= 8);
      m_v[i]     = f ? 0 : r;
      m_acc[i]   = 0;
      m_fired[i] = f;
      if (f) fires.push_back(i);
    end
  endtask

  task automatic send_event(input int addr, input int w);
    in_valid  = 1'b1;
    in_addr   = addr[1:0];
    in_weight = w[4:0];
    check("ev_ready", in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    model_event(addr, w);
  endtask

  task automatic check_state(input string tag);
    for (int i = 0; i < N; i++) check({tag, "_v"}, dut.v_q[i], m_v[i]);
    check({tag, "_ovr"}, tick_overrun, m_overrun);
  endtask

  task automatic run_sweep(input int stall_n, input bit rand_rdy, input bit ovr,
                           input bit ev_tick, input int ev_addr, input int ev_w);
    int exp_q[$];
    int got_q[$];
    int k, stalls, stall_left;
    bit done, prev_stall, rdy;
    logic [1:0] prev_addr;
    if (ev_tick) begin
      in_valid = 1'b1; in_addr = ev_addr[1:0]; in_weight = ev_w[4:0];
      model_event(ev_addr, ev_w);
    end
    tick = 1'b1;
    model_sweep(exp_q);
    @(posedge clk); #1;
    tick = 1'b0; in_valid = 1'b0;
    k = 0; stalls = 0; stall_left = stall_n; done = 0; prev_stall = 0; prev_addr = '0;
    while (!done && k < N + 40) begin
      if (sweep_done) begin
        done = 1;
      end else begin
        if (k == 0) check("busy_ready", in_ready, 0);
        if (prev_stall) begin
          check("hold_valid", out_valid, 1);
          check("hold_addr", out_addr, prev_addr);
        end
        if (out_valid && stall_left > 0) begin
          rdy = 1'b0; stall_left--;
        end else if (rand_rdy) rdy = 1'($urandom_range(0, 1));
        else rdy = 1'b1;
        out_ready = rdy;
        if (ovr && k == 1) begin
          tick = 1'b1; in_valid = 1'b1;
          in_addr = 2'($urandom_range(0, 3)); in_weight = 5'($urandom_range(1, 31));
          m_overrun = 1;
        end
        prev_stall = out_valid && !out_ready;
        prev_addr  = out_addr;
        if (out_valid && out_ready) got_q.push_back(int'(out_addr));
        if (prev_stall) stalls++;
        @(posedge clk); #1;
        tick = 1'b0; in_valid = 1'b0;
        k++;
      end
    end
    out_ready = 1'b1;
    check("sweep_done_seen", done, 1);
    check("latency", k, N + stalls);
    if (stall_n > 0) check("stalls", stalls, stall_n);
    check("spike_cnt", got_q.size(), exp_q.size());
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) check("spike_addr", got_q[i], exp_q[i]);
    @(posedge clk); #1;
    check("done_pulse", sweep_done, 0);
    check("idle_ready", in_ready, 1);
    check_state("post");
  endtask

  initial begin
    model_reset();
    @(posedge clk); #1;
    check("rst_ready", in_ready, 1);
    check("rst_valid", out_valid, 0);
    check("rst_addr", out_addr, 0);
    check("rst_done", sweep_done, 0);
    check("rst_ovr", tick_overrun, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Accumulate then fire on neuron 2.
    send_event(2, 5);
    run_sweep(0, 0, 0, 0, 0, 0);
    check("v2_leak", dut.v_q[2], 4);
    send_event(2, 5);
    run_sweep(0, 0, 0, 0, 0, 0);
    check("v2_fire", dut.v_q[2], 0);

    // Saturating accumulation.
    send_event(0, 31);
    send_event(0, 31);
    check("acc0_sat", dut.acc_q[0], 31);
    run_sweep(0, 0, 0, 0, 0, 0);

    // Backpressure on a neuron 1 spike.
    send_event(1, 9);
    run_sweep(3, 0, 0, 0, 0, 0);

    // Overrun tick plus a refused event mid-sweep.
    send_event(3, 2);
    run_sweep(0, 0, 1, 0, 0, 0);
    check("ovr_set", tick_overrun, 1);

    // Reset in the middle of a sweep.
    send_event(0, 31);
    tick = 1'b1;
    @(posedge clk); #1;
    tick = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    check("mid_rst_ready", in_ready, 1);
    check("mid_rst_valid", out_valid, 0);
    check("mid_rst_done", sweep_done, 0);
    check("mid_rst_ovr", tick_overrun, 0);
    for (int i = 0; i < N; i++) check("mid_rst_v", dut.v_q[i], 0);
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
    run_sweep(0, 0, 0, 0, 0, 0);

    // Refractory behaviour on neuron 3.
    send_event(3, 15);
    run_sweep(0, 0, 0, 0, 0, 0);
    check("v3_fire", dut.v_q[3], 0);
    send_event(3, 15);
    run_sweep(0, 0, 0, 0, 0, 0);
    check("v3_after", dut.v_q[3], 0);

    // Randomized traffic, random backpressure, events coincident with tick.
    for (int it = 0; it < 25; it++) begin
      int n_ev, a, w;
      n_ev = $urandom_range(0, 4);
      for (int e = 0; e < n_ev; e++) begin
        a = $urandom_range(0, N - 1);
        w = ($urandom_range(0, 3) == 0) ? $urandom_range(16, 31) : $urandom_range(0, 12);
        send_event(a, w);
      end
      a = $urandom_range(0, N - 1);
      w = $urandom_range(0, 15);
      run_sweep(0, 1, ($urandom_range(0, 4) == 0), ($urandom_range(0, 1) == 1), a, w);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/lif_scheduler.md
LIF_SCHEDULER -- requirements
Module: lif_scheduler

Interface
REQ-001 SHALL have parameter V_SIZE, default 4: membrane voltage width; currents are V_SIZE+1 bits with the MSB as the overflow/saturation flag.
REQ-002 SHALL have parameter N_NEURONS, default 4: number of time-multiplexed neurons, at least 2; AW = $clog2(N_NEURONS).
REQ-003 SHALL have parameter THRESHOLD, default 8: fire level, from 1 to 2^V_SIZE-1.
REQ-004 SHALL have parameter LEAK, default 1: per-timestep leak subtracted from each neuron.
REQ-005 SHALL have port clk, input, 1 bit: the single clock, rising edge.
REQ-006 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-007 SHALL have port tick, input, 1 bit: one-cycle timestep strobe.
REQ-008 SHALL have port in_valid, input, 1 bit: an input spike event is offered.
REQ-009 SHALL have port in_ready, output, 1 bit: an input event is accepted on in_valid && in_ready.
REQ-010 SHALL have port in_addr, input, AW bits: target neuron index.
REQ-011 SHALL have port in_weight, input, V_SIZE+1 bits: synaptic current of the event.
REQ-012 SHALL have port out_valid, output, 1 bit: an output spike event is presented.
REQ-013 SHALL have port out_ready, input, 1 bit: the output event is consumed on out_valid && out_ready.
REQ-014 SHALL have port out_addr, output, AW bits: index of the neuron that fired.
REQ-015 SHALL have port sweep_done, output, 1 bit: one-cycle pulse when a timestep sweep completes.
REQ-016 SHALL have port tick_overrun, output, 1 bit: sticky flag, set when a tick arrives while busy.

Function
REQ-017 SHALL keep per-neuron state in registers: voltage v[i] (V_SIZE bits) and accumulated current acc[i] (V_SIZE+1 bits).
REQ-018 SHALL implement an FSM with states IDLE, SWEEP and HOLD; in_ready SHALL be 1 only in IDLE.
REQ-019 SHALL, in IDLE, clip-add an accepted event into acc[in_addr]: the result is all-ones (V_SIZE+1 bits) if either operand MSB or the sum MSB is set, otherwise the sum.
REQ-020 SHALL accept and silently drop events with in_addr >= N_NEURONS.
REQ-021 SHALL, on tick in IDLE, move to SWEEP with index 0; an event accepted in the same cycle SHALL be included in that sweep.
REQ-022 SHALL, in SWEEP at index i, compute s = {0,v[i]} + acc[i] and r:
  - r = all-ones if acc[i] MSB is set;
  - otherwise r = s - LEAK if s > LEAK, saturating to all-ones if bit V_SIZE of the difference is set;
  - otherwise r = 0.
REQ-023 SHALL treat r >= THRESHOLD as fire: v[i] becomes 0; otherwise v[i] becomes r[V_SIZE-1:0]. acc[i] SHALL clear to 0 in the same cycle v[i] is written.
REQ-024 SHALL, for a non-firing neuron, commit the update and advance the index in one cycle.
REQ-025 SHALL, for a firing neuron, drive out_valid=1 and out_addr=i combinationally in SWEEP and commit only on out_ready.
REQ-026 SHALL, if out_ready=0 while firing, enter HOLD. In HOLD, out_valid and out_addr SHALL stay stable and no state SHALL change until out_ready=1; then commit and advance.
REQ-027 SHALL, after committing index N_NEURONS-1, return to IDLE and pulse sweep_done for exactly one cycle, registered, in the first IDLE cycle.
REQ-028 SHALL have a sweep latency of N_NEURONS cycles from the tick edge to the return to IDLE when there is no backpressure, plus one cycle per stalled cycle.
REQ-029 SHALL ignore a tick in SWEEP or HOLD and set tick_overrun, which clears only on reset.

Reset
REQ-030 SHALL, while rst is asserted, asynchronously clear all v[i], acc[i], the index and tick_overrun, and force state IDLE.
REQ-031 SHALL drive these values under reset: in_ready=1, out_valid=0, out_addr=0, sweep_done=0.
REQ-032 SHALL, when reset is asserted mid-sweep, abandon the sweep and emit no sweep_done.

Configuration
REQ-033 SHALL, with LIF_SCHED_REFRACTORY_EN defined, keep a per-neuron fired flag. In the sweep after a neuron fired, that neuron's acc SHALL be treated as 0 (leak still applies) and acc SHALL still clear; the flag then updates from the new fire result.
REQ-034 SHALL, without LIF_SCHED_REFRACTORY_EN, have no fired-flag storage and use acc unconditionally.

Verification (V_SIZE=4, N_NEURONS=4, THRESHOLD=8, LEAK=1)
REQ-035 SHALL verify reset: assert rst mid-sweep -> in_ready=1, out_valid=0, sweep_done=0, all v=0; the next tick sweep with no events gives no out_valid.
REQ-036 SHALL verify accumulate-and-fire: event addr 2 weight 5, tick -> v[2]=4, no spike; event addr 2 weight 5, tick -> out_valid with out_addr=2 (r=8), v[2]=0.
REQ-037 SHALL verify saturation: two events addr 0 weight 5'h1F -> acc[0]=5'h1F; tick -> spike on addr 0.
REQ-038 SHALL verify backpressure: spike on addr 1 with out_ready=0 for 3 cycles -> out_valid and out_addr=1 held 3 cycles; sweep_done arrives 3 cycles later than unstalled.
REQ-039 SHALL verify overrun: tick during SWEEP -> tick_overrun=1, exactly one sweep_done; an in_valid during SWEEP is not accepted.
REQ-040 SHALL verify refractory (macro on): addr 3 fires, then weight 15 event, tick -> no spike, v[3]=0; same sequence with macro off -> spike on addr 3.
